// File: rtl/apb_arb_pkg.sv
// Shared types for the two-requester APB command arbiter.
// Holds the FSM state encoding, requester id type and timeout default.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    typedef logic req_id_t;

    localparam req_id_t REQ0 = 1'b0;
    localparam req_id_t REQ1 = 1'b1;

    localparam int unsigned TIMEOUT_CYCLES_DEF = 16;

endpackage

// File: rtl/apb_rr_arb2.sv
// Two-way round-robin grant with a pointer that moves to the
// requester that was not served once a response completes.
module apb_rr_arb2
    import apb_arb_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic       i_upd,
    input  req_id_t    i_done_id,
    output logic       o_gnt_vld,
    output req_id_t    o_gnt_id
);

    req_id_t r_ptr;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ptr <= REQ0;
        end else if (i_upd) begin
            r_ptr <= ~i_done_id;
        end
    end

    // The pointer only matters when both requesters contend.
    always_comb begin
        o_gnt_vld = |i_req;
        o_gnt_id  = (&i_req) ? r_ptr : i_req[1];
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Arbitrates two command requesters onto one APB master command port.
// Define APB_ARB_TIMEOUT_EN to abort WAIT after TIMEOUT_CYCLES cycles.
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic       pclk,
    input  logic       presetn,
    input  logic       req0_valid,
    input  logic       req1_valid,
    input  logic       req0_write,
    input  logic       req1_write,
    input  logic [7:0] req0_addr,
    input  logic [7:0] req1_addr,
    input  logic [7:0] req0_wdata,
    input  logic [7:0] req1_wdata,
    output logic       req0_ready,
    output logic       req1_ready,
    output logic       rsp0_valid,
    output logic       rsp1_valid,
    output logic [7:0] rsp0_rdata,
    output logic [7:0] rsp1_rdata,
    output logic       rsp0_err,
    output logic       rsp1_err,
    output logic       transfer,
    output logic       READ_WRITE,
    output logic [7:0] apb_write_paddr,
    output logic [7:0] apb_write_data,
    output logic [7:0] apb_read_paddr,
    input  logic [7:0] apb_read_data_out,
    input  logic       apb_done
);

    state_t     r_state;
    state_t     w_next;
    req_id_t    r_gid;
    logic       r_write;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic [7:0] r_rdata;
    logic       r_err;

    logic       w_gnt_vld;
    req_id_t    w_gnt_id;
    logic       w_grant;
    logic       w_xfer;
    logic       w_resp;
    logic       w_timeout;

    apb_rr_arb2 u_rr (
        .i_clk     (pclk),
        .i_rst_n   (presetn),
        .i_req     ({req1_valid, req0_valid}),
        .i_upd     (w_resp),
        .i_done_id (r_gid),
        .o_gnt_vld (w_gnt_vld),
        .o_gnt_id  (w_gnt_id)
    );

    assign w_grant = (r_state == S_IDLE) && w_gnt_vld && presetn;
    assign w_xfer  = (r_state == S_ISSUE) || (r_state == S_WAIT);
    assign w_resp  = (r_state == S_RESP);

`ifdef APB_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge pclk) begin
        if (!presetn || r_state != S_WAIT) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A completion arriving on the last allowed cycle still wins.
    assign w_timeout = (r_state == S_WAIT) && !apb_done
                    && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
    assign w_timeout    = 1'b0;
`endif

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_gnt_vld) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (apb_done || w_timeout) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_gid   <= REQ0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_grant) begin
            r_gid   <= w_gnt_id;
            r_write <= w_gnt_id ? req1_write : req0_write;
            r_addr  <= w_gnt_id ? req1_addr  : req0_addr;
            r_wdata <= w_gnt_id ? req1_wdata : req0_wdata;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (r_state == S_WAIT) begin
            if (apb_done && !r_write) r_rdata <= apb_read_data_out;
            if (w_timeout) r_err <= 1'b1;
        end
    end

    always_comb begin
        req0_ready      = 1'b0;
        req1_ready      = 1'b0;
        rsp0_valid      = 1'b0;
        rsp1_valid      = 1'b0;
        rsp0_rdata      = '0;
        rsp1_rdata      = '0;
        rsp0_err        = 1'b0;
        rsp1_err        = 1'b0;
        transfer        = 1'b0;
        READ_WRITE      = 1'b0;
        apb_write_paddr = '0;
        apb_write_data  = '0;
        apb_read_paddr  = '0;
        if (w_grant) begin
            req0_ready = (w_gnt_id == REQ0);
            req1_ready = (w_gnt_id == REQ1);
        end
        if (w_xfer) begin
            transfer   = 1'b1;
            READ_WRITE = ~r_write;
            if (r_write) begin
                apb_write_paddr = r_addr;
                apb_write_data  = r_wdata;
            end else begin
                apb_read_paddr  = r_addr;
            end
        end
        if (w_resp) begin
            if (r_gid == REQ1) begin
                rsp1_valid = 1'b1;
                rsp1_rdata = r_rdata;
                rsp1_err   = r_err;
            end else begin
                rsp0_valid = 1'b1;
                rsp0_rdata = r_rdata;
                rsp0_err   = r_err;
            end
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed self-checking bench for apb_req_arbiter.
// Honours APB_ARB_TIMEOUT_EN to pick the timeout expectation.
module tb_apb_req_arbiter;

    logic       pclk = 1'b0;
    logic       presetn;
    logic       req0_valid, req1_valid;
    logic       req0_write, req1_write;
    logic [7:0] req0_addr, req1_addr;
    logic [7:0] req0_wdata, req1_wdata;
    logic       req0_ready, req1_ready;
    logic       rsp0_valid, rsp1_valid;
    logic [7:0] rsp0_rdata, rsp1_rdata;
    logic       rsp0_err, rsp1_err;
    logic       transfer, READ_WRITE;
    logic [7:0] apb_write_paddr, apb_write_data, apb_read_paddr;
    logic [7:0] apb_read_data_out;
    logic       apb_done;

    int total = 0;
    int bad   = 0;

    always #5 pclk = ~pclk;

    apb_req_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .pclk              (pclk),
        .presetn           (presetn),
        .req0_valid        (req0_valid),
        .req1_valid        (req1_valid),
        .req0_write        (req0_write),
        .req1_write        (req1_write),
        .req0_addr         (req0_addr),
        .req1_addr         (req1_addr),
        .req0_wdata        (req0_wdata),
        .req1_wdata        (req1_wdata),
        .req0_ready        (req0_ready),
        .req1_ready        (req1_ready),
        .rsp0_valid        (rsp0_valid),
        .rsp1_valid        (rsp1_valid),
        .rsp0_rdata        (rsp0_rdata),
        .rsp1_rdata        (rsp1_rdata),
        .rsp0_err          (rsp0_err),
        .rsp1_err          (rsp1_err),
        .transfer          (transfer),
        .READ_WRITE        (READ_WRITE),
        .apb_write_paddr   (apb_write_paddr),
        .apb_write_data    (apb_write_data),
        .apb_read_paddr    (apb_read_paddr),
        .apb_read_data_out (apb_read_data_out),
        .apb_done          (apb_done)
    );

    typedef struct {
        bit         rq;
        bit         wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] mrd;
        int         k;
        bit         early;
        logic [7:0] exp_rd;
        logic       exp_rw;
        logic [7:0] exp_wa;
        logic [7:0] exp_wd;
        logic [7:0] exp_ra;
    } vec_t;

    vec_t vt [5];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic smp();
        @(negedge pclk);
    endtask

    task automatic set_req(input bit r, input bit v, input bit w,
                           input logic [7:0] a, input logic [7:0] d);
        if (r) begin
            req1_valid = v; req1_write = w; req1_addr = a; req1_wdata = d;
        end else begin
            req0_valid = v; req0_write = w; req0_addr = a; req0_wdata = d;
        end
    endtask

    // Entered and left at posedge+1 with the FSM idle.
    task automatic run_txn(input vec_t v);
        set_req(v.rq, 1'b1, v.wr, v.addr, v.wdata);
        smp();
        chk("grant", {req1_ready, req0_ready}, v.rq ? 2'b10 : 2'b01);
        step();
        set_req(v.rq, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int c = 1; c <= v.k; c++) begin
            apb_done = (c == v.k) || (c == 1 && v.early);
            apb_read_data_out = (c == 1 && v.early) ? 8'hEE : v.mrd;
            smp();
            chk("xfer", transfer, 1);
            chk("rw", READ_WRITE, v.exp_rw);
            chk("wpaddr", apb_write_paddr, v.exp_wa);
            chk("wdata", apb_write_data, v.exp_wd);
            chk("rpaddr", apb_read_paddr, v.exp_ra);
            chk("no_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
            chk("no_rdy", {req1_ready, req0_ready}, 2'b00);
            step();
        end
        apb_done = 1'b0;
        apb_read_data_out = 8'h00;
        smp();
        chk("xfer_drop", transfer, 0);
        chk("rsp_v", {rsp1_valid, rsp0_valid}, v.rq ? 2'b10 : 2'b01);
        chk("rsp_rd", v.rq ? rsp1_rdata : rsp0_rdata, v.exp_rd);
        chk("rsp_err", v.rq ? rsp1_err : rsp0_err, 0);
        step();
        smp();
        chk("idle", {rsp1_valid, rsp0_valid, transfer}, 3'b000);
        step();
    endtask

    initial begin
        vt[0] = '{0, 1, 8'h10, 8'hA5, 8'h77, 3, 0, 8'h00, 0, 8'h10, 8'hA5, 8'h00};
        vt[1] = '{1, 0, 8'h22, 8'h00, 8'h5C, 2, 0, 8'h5C, 1, 8'h00, 8'h00, 8'h22};
        vt[2] = '{0, 0, 8'hFF, 8'h33, 8'h81, 5, 1, 8'h81, 1, 8'h00, 8'h00, 8'hFF};
        vt[3] = '{1, 1, 8'h00, 8'hFF, 8'h12, 2, 0, 8'h00, 0, 8'h00, 8'hFF, 8'h00};
        vt[4] = '{1, 0, 8'h7E, 8'h00, 8'h00, 4, 1, 8'h00, 1, 8'h00, 8'h00, 8'h7E};

        presetn = 1'b0;
        set_req(0, 1'b1, 1'b1, 8'h55, 8'h66);
        set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
        apb_done = 1'b0;
        apb_read_data_out = 8'h00;
        step();
        step();
        smp();
        chk("rst_rdy", {req1_ready, req0_ready}, 2'b00);
        chk("rst_out", {transfer, READ_WRITE, rsp1_valid, rsp0_valid,
                        rsp1_err, rsp0_err}, 6'b0);
        chk("rst_fld", {apb_write_paddr, apb_write_data, apb_read_paddr,
                        rsp0_rdata}, 32'h0);
        step();
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        presetn = 1'b1;
        step();

        for (int i = 0; i < 5; i++) run_txn(vt[i]);

        // Both requesters held: strict alternation starting at req0.
        presetn = 1'b0;
        step();
        presetn = 1'b1;
        set_req(0, 1'b1, 1'b1, 8'h30, 8'h3C);
        set_req(1, 1'b1, 1'b0, 8'h31, 8'h00);
        for (int g = 0; g < 4; g++) begin
            smp();
            chk("rr_order", {req1_ready, req0_ready},
                (g % 2) ? 2'b10 : 2'b01);
            step();
            smp();
            chk("rr_issue_rdy", {req1_ready, req0_ready}, 2'b00);
            step();
            apb_done = 1'b1;
            apb_read_data_out = 8'h99;
            smp();
            chk("rr_wait_rdy", {req1_ready, req0_ready}, 2'b00);
            step();
            apb_done = 1'b0;
            smp();
            chk("rr_rsp", {rsp1_valid, rsp0_valid}, (g % 2) ? 2'b10 : 2'b01);
            chk("rr_rdata", rsp1_rdata, (g % 2) ? 8'h99 : 8'h00);
            step();
        end
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
        step();

        // Reset in WAIT drops the command and restores the pointer to req0.
        run_txn(vt[0]);
        set_req(1, 1'b1, 1'b0, 8'h44, 8'h00);
        smp();
        chk("rw_grant1", {req1_ready, req0_ready}, 2'b10);
        step();
        set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
        step();
        presetn = 1'b0;
        apb_read_data_out = 8'hDD;
        smp();
        chk("rw_in_wait", transfer, 1);
        step();
        presetn = 1'b1;
        set_req(0, 1'b1, 1'b0, 8'h50, 8'h00);
        set_req(1, 1'b1, 1'b0, 8'h44, 8'h00);
        smp();
        chk("rw_xfer0", transfer, 0);
        chk("rw_norsp", {rsp1_valid, rsp0_valid}, 2'b00);
        chk("rw_ptr0", {req1_ready, req0_ready}, 2'b01);
        step();
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
        smp();
        chk("rw_rpaddr", apb_read_paddr, 8'h50);
        step();
        apb_done = 1'b1;
        apb_read_data_out = 8'h42;
        step();
        apb_done = 1'b0;
        smp();
        chk("rw_rsp", {rsp1_valid, rsp0_valid}, 2'b01);
        chk("rw_rdata", rsp0_rdata, 8'h42);
        step();
        step();

        // No completion: abort after 4 WAIT cycles, or hang in WAIT.
        set_req(1, 1'b1, 1'b0, 8'h40, 8'h00);
        step();
        set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
        apb_read_data_out = 8'hAB;
        for (int c = 1; c <= 5; c++) begin
            smp();
            chk("to_xfer", transfer, 1);
            chk("to_norsp", {rsp1_valid, rsp0_valid}, 2'b00);
            step();
        end
`ifdef APB_ARB_TIMEOUT_EN
        smp();
        chk("to_rsp", rsp1_valid, 1);
        chk("to_err", rsp1_err, 1);
        chk("to_rdata", rsp1_rdata, 8'h00);
        chk("to_xfer_off", transfer, 0);
        step();
`else
        for (int c = 6; c <= 20; c++) begin
            smp();
            chk("hang_xfer", transfer, 1);
            chk("hang_norsp", {rsp1_valid, rsp0_valid}, 2'b00);
            step();
        end
        presetn = 1'b0;
        step();
        presetn = 1'b1;
        smp();
        chk("hang_rst", transfer, 0);
        step();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_req_arbiter.md
APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: maximum WAIT cycles before abort (used only with APB_ARB_TIMEOUT_EN).
REQ-002 pclk  in  1  single clock; all logic on posedge.
REQ-003 presetn  in  1  reset, synchronous, active-low.
REQ-004 req0_valid, req1_valid  in  1  requester N has a command pending.
REQ-005 req0_write, req1_write  in  1  1 = write, 0 = read.
REQ-006 req0_addr, req1_addr  in  8  target address.
REQ-007 req0_wdata, req1_wdata  in  8  write data.
REQ-008 req0_ready, req1_ready  out  1  command accepted this cycle.
REQ-009 rsp0_valid, rsp1_valid  out  1  one-cycle completion pulse.
REQ-010 rsp0_rdata, rsp1_rdata  out  8  read data, valid with rspN_valid; 0 for writes.
REQ-011 rsp0_err, rsp1_err  out  1  timeout abort flag, valid with rspN_valid.
REQ-012 transfer  out  1  APB transfer request to master.
REQ-013 READ_WRITE  out  1  1 = read, 0 = write.
REQ-014 apb_write_paddr, apb_write_data, apb_read_paddr  out  8 each  master command fields.
REQ-015 apb_read_data_out  in  8  read data from master.
REQ-016 apb_done  in  1  one-cycle pulse: master completed access phase.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-018 IDLE: if any reqN_valid, grant per round-robin, assert granted reqN_ready for exactly that cycle, latch write/addr/wdata, go ISSUE; else stay.
REQ-019 Both valid in IDLE: grant goes to requester indicated by RR pointer; other sees ready=0 and keeps valid.
REQ-020 RR pointer SHALL point to the non-granted requester after each RESP; single requester may be granted back-to-back.
REQ-021 ISSUE (1 cycle) and WAIT: transfer=1, READ_WRITE=~latched write, command fields stable from latch.
REQ-022 Write: apb_write_paddr/apb_write_data = latched; apb_read_paddr=0. Read: apb_read_paddr = latched; write fields=0.
REQ-023 apb_done in ISSUE SHALL be ignored; WAIT + apb_done: capture apb_read_data_out (reads), drop transfer next cycle, go RESP.
REQ-024 RESP (1 cycle): granted rspN_valid=1 with rdata/err; go IDLE; new grant earliest cycle after RESP.
REQ-025 Minimum latency: ready at cycle 0, transfer cycles 1..k, rsp at k+1 where apb_done seen at cycle k>=2.
REQ-026 Outside ISSUE/WAIT transfer=0 and all command fields=0; at most one requester granted at any time.

Reset
REQ-027 presetn=0 at a posedge: FSM->IDLE, RR pointer->req0, all outputs 0, latches cleared.
REQ-028 Reset mid-transfer SHALL abandon the command with no response pulse.

Configuration
REQ-029 Macro APB_ARB_TIMEOUT_EN defined: WAIT counter; TIMEOUT_CYCLES WAIT cycles without apb_done -> RESP with rspN_err=1, rdata=0.
REQ-030 Macro undefined: no counter, WAIT indefinitely, rspN_err tied 0.

Structure
REQ-031 Package apb_arb_pkg SHALL hold state enum, requester-id type, TIMEOUT_CYCLES default.
REQ-032 Sub-module apb_rr_arb2 SHALL implement 2-way RR grant and pointer update.

Verification
REQ-033 req0 write addr 0x10 data 0xA5, apb_done at cycle 3 -> transfer=1 cycles 1-3, READ_WRITE=0, rsp0_valid at cycle 4, rsp0_rdata=0.
REQ-034 req1 read addr 0x22, master returns 0x5C with apb_done -> READ_WRITE=1, apb_read_paddr=0x22, rsp1_rdata=0x5C.
REQ-035 Both valid from reset, held -> order req0, req1, req0, req1; never both ready.
REQ-036 presetn low while in WAIT -> next cycle transfer=0, no rsp pulse, next grant to req0.
REQ-037 APB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, no apb_done -> rsp pulse with err=1 after 4 WAIT cycles; without macro FSM stays WAIT.
REQ-038 apb_done pulsed during ISSUE -> ignored, FSM still waits for later apb_done.
